// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES word-stream front/back end
package aes_pkg;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_WORD_W  = 32;
   localparam int AES_WORDS   = 4;
   typedef logic [AES_BLOCK_W-1:0] aes_block_t;
   typedef logic [AES_WORD_W-1:0]  aes_word_t;
   typedef enum logic [1:0] {FILL, WAIT, DRAIN} aes_state_e;
endpackage

// File: rtl/aes_word_buffer.sv
// aes_word_buffer: 4x32 register, indexed word write/read plus 128-bit parallel load/read
// Ports: clk, rst (sync, active-high); wr_en_i/wr_idx_i/wr_data_i word write;
//        ld_en_i/ld_data_i parallel load (wins over word write); rd_idx_i/rd_data_o word read;
//        par_o whole block, word 0 in [127:96].
module aes_word_buffer
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en_i,
   input  logic [1:0] wr_idx_i,
   input  aes_word_t  wr_data_i,
   input  logic       ld_en_i,
   input  aes_block_t ld_data_i,
   input  logic [1:0] rd_idx_i,
   output aes_word_t  rd_data_o,
   output aes_block_t par_o
);
   // Ascending packed range puts word 0 in the most significant bits (big-endian).
   logic [0:AES_WORDS-1][AES_WORD_W-1:0] buf_q, buf_d;
   always_comb begin
      buf_d = ld_en_i ? ld_data_i : buf_q;
      if (wr_en_i && !ld_en_i) buf_d[wr_idx_i] = wr_data_i;
   end
   always_ff @(posedge clk) begin
      if (rst) buf_q <= '0;
      else     buf_q <= buf_d;
   end
   assign rd_data_o = buf_q[rd_idx_i];
   assign par_o     = buf_q;
endmodule

// File: rtl/aes_word_stream_io.sv
// aes_word_stream_io: 32-bit stream packer/unpacker around a combinational AES-128 core
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data/s_key input word stream;
//        m_valid/m_ready/m_data/m_last ciphertext word stream; key_loaded full key held;
//        err_nokey pulse on data word without key; core_in/core_key/core_out core link.
// Optional: define AES_IO_BLOCK_COUNT_EN to add blk_count (16-bit count of drained blocks).
module aes_word_stream_io
   import aes_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  aes_word_t  s_data,
   input  logic       s_key,
   output logic       m_valid,
   input  logic       m_ready,
   output aes_word_t  m_data,
   output logic       m_last,
   output logic       key_loaded,
   output logic       err_nokey,
   output aes_block_t core_in,
   output aes_block_t core_key,
`ifdef AES_IO_BLOCK_COUNT_EN
   output logic [15:0] blk_count,
`endif
   input  aes_block_t core_out
);
   aes_state_e state_q, state_d;
   logic [1:0] key_idx_q, key_idx_d, data_idx_q, data_idx_d, out_idx_q, out_idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       key_loaded_q, key_loaded_d, err_q, err_d;
   logic       acc, key_wr, dat_wr, capture, m_hs, done;
   aes_word_t  out_word, key_rd_unused, blk_rd_unused;

   assign s_ready = state_q == FILL;
   assign m_valid = state_q == DRAIN;
   assign m_last  = m_valid && out_idx_q == 2'd3;
   assign m_data  = m_valid ? out_word : '0;
   assign key_loaded = key_loaded_q;
   assign err_nokey  = err_q;

   assign acc     = s_valid & s_ready;
   assign key_wr  = acc & s_key;
   assign dat_wr  = acc & ~s_key & key_loaded_q;
   // Core inputs have been stable for SETTLE cycles when the counter hits SETTLE-1.
   assign capture = state_q == WAIT && cnt_q == 4'(SETTLE - 1);
   assign m_hs    = m_valid & m_ready;
   assign done    = m_hs & m_last;

   always_comb begin
      state_d = state_q == FILL ? ((dat_wr && data_idx_q == 2'd3) ? WAIT : FILL)
              : state_q == WAIT ? (capture ? DRAIN : WAIT)
              : (done ? FILL : DRAIN);
      key_idx_d    = key_wr ? key_idx_q + 2'd1 : key_idx_q;
      key_loaded_d = !key_wr ? key_loaded_q
                   : key_idx_q == 2'd0 ? 1'b0
                   : key_idx_q == 2'd3 ? 1'b1 : key_loaded_q;
      data_idx_d   = dat_wr ? data_idx_q + 2'd1 : done ? 2'd0 : data_idx_q;
      out_idx_d    = capture ? 2'd0 : m_hs ? out_idx_q + 2'd1 : out_idx_q;
      cnt_d        = state_q == WAIT ? cnt_q + 4'd1 : 4'd0;
      err_d        = acc & ~s_key & ~key_loaded_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         key_idx_q    <= '0;
         data_idx_q   <= '0;
         out_idx_q    <= '0;
         cnt_q        <= '0;
         key_loaded_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_idx_q    <= key_idx_d;
         data_idx_q   <= data_idx_d;
         out_idx_q    <= out_idx_d;
         cnt_q        <= cnt_d;
         key_loaded_q <= key_loaded_d;
         err_q        <= err_d;
      end
   end

`ifdef AES_IO_BLOCK_COUNT_EN
   logic [15:0] blk_q;
   always_ff @(posedge clk) begin
      if (rst)       blk_q <= '0;
      else if (done) blk_q <= blk_q + 16'd1;
   end
   assign blk_count = blk_q;
`endif

   aes_word_buffer u_key (
      .clk(clk), .rst(rst),
      .wr_en_i(key_wr), .wr_idx_i(key_idx_q), .wr_data_i(s_data),
      .ld_en_i(1'b0), .ld_data_i('0),
      .rd_idx_i(2'd0), .rd_data_o(key_rd_unused), .par_o(core_key)
   );
   aes_word_buffer u_blk (
      .clk(clk), .rst(rst),
      .wr_en_i(dat_wr), .wr_idx_i(data_idx_q), .wr_data_i(s_data),
      .ld_en_i(1'b0), .ld_data_i('0),
      .rd_idx_i(2'd0), .rd_data_o(blk_rd_unused), .par_o(core_in)
   );
   aes_word_buffer u_out (
      .clk(clk), .rst(rst),
      .wr_en_i(1'b0), .wr_idx_i(2'd0), .wr_data_i('0),
      .ld_en_i(capture), .ld_data_i(core_out),
      .rd_idx_i(out_idx_q), .rd_data_o(out_word), .par_o()
   );
endmodule

// File: tb/tb_aes_word_stream_io.sv
// tb_aes_word_stream_io: scoreboard bench for aes_word_stream_io with a lookup-table core stub
module tb_aes_word_stream_io;
   localparam int SETTLE = 2;
   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P_F  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C_F  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   typedef struct { logic [31:0] data; logic last; } exp_t;

   logic clk, rst, s_valid, s_ready, s_key, m_valid, m_ready, m_last, key_loaded, err_nokey;
   logic [31:0] s_data, m_data;
   logic [127:0] core_in, core_key, core_out;
`ifdef AES_IO_BLOCK_COUNT_EN
   logic [15:0] blk_count;
`endif

   exp_t exp_q[$];
   int n_cmp = 0, n_err = 0, err_cnt = 0, stall_n = 0;
   bit rnd = 0, busy = 0, mv_prev = 0;
   longint t_acc = 0;

   aes_word_stream_io #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .key_loaded(key_loaded), .err_nokey(err_nokey), .core_in(core_in), .core_key(core_key),
`ifdef AES_IO_BLOCK_COUNT_EN
      .blk_count(blk_count),
`endif
      .core_out(core_out)
   );

   function automatic logic [127:0] core_model(input logic [127:0] pt, input logic [127:0] key);
      if (key == K_C1 && pt == P_C1) return C_C1;
      if (key == K_B && pt == P_B) return C_B;
      if (key == K_B && pt == P_F) return C_F;
      return pt ^ {key[63:0], key[127:64]};
   endfunction

   always_comb core_out = core_model(core_in, core_key);

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      m_ready = 1;
      forever begin
         @(negedge clk);
         m_ready = stall_n > 0 ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall_n > 0) stall_n--;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("s_ready", 128'(s_ready), 128'(!busy));
            if (err_nokey) err_cnt++;
            if (m_valid && !mv_prev) chk("latency", 128'((($time - t_acc) - 7) / 10), 128'(SETTLE));
            if (m_valid) begin
               if (exp_q.size() == 0) chk("unexpected_output", 128'(m_data), 128'hx);
               else begin
                  chk("m_data", 128'(m_data), 128'(exp_q[0].data));
                  chk("m_last", 128'(m_last), 128'(exp_q[0].last));
                  if (m_ready) begin
                     if (exp_q[0].last) busy = 0;
                     void'(exp_q.pop_front());
                  end
               end
            end
         end
         mv_prev = m_valid;
      end
   end

   task automatic send(input logic k, input logic [31:0] d, input bit last);
      int g = 0;
      s_valid = 1; s_key = k; s_data = d;
      while (!s_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g == 200) chk("s_ready_timeout", 128'(s_ready), 128'(1));
      @(posedge clk);
      if (last) begin
         t_acc = $time;
         busy = 1;
      end
      @(negedge clk);
   endtask

   task automatic run_blk(input bit with_key, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] ct);
      if (with_key) for (int i = 0; i < 4; i++) send(1, key[127-32*i -: 32], 0);
      for (int i = 0; i < 4; i++) exp_q.push_back('{ct[127-32*i -: 32], i == 3});
      for (int i = 0; i < 4; i++) send(0, pt[127-32*i -: 32], i == 3);
      s_valid = 0;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() > 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("drain_left", 128'(exp_q.size()), 128'(0));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int e0, g;
      logic [127:0] p3, p4, p5;
      rst = 1; s_valid = 0; s_key = 0; s_data = 0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 128'(s_ready), 128'(1));
      chk("rst_m_valid", 128'(m_valid), 128'(0));
      chk("rst_m_last", 128'(m_last), 128'(0));
      chk("rst_m_data", 128'(m_data), 128'(0));
      chk("rst_key_loaded", 128'(key_loaded), 128'(0));
      chk("rst_err", 128'(err_nokey), 128'(0));
      chk("rst_core_in", core_in, 128'(0));
      chk("rst_core_key", core_key, 128'(0));
      rst = 0;
      @(negedge clk);

      e0 = err_cnt;
      for (int i = 0; i < 4; i++) send(0, 32'hdead0000 + 32'(i), 0);
      s_valid = 0;
      repeat (3) @(negedge clk);
      chk("nokey_err_count", 128'(err_cnt - e0), 128'(4));
      chk("nokey_key_loaded", 128'(key_loaded), 128'(0));

      run_blk(1, K_C1, P_C1, C_C1);
      chk("c1_key_loaded", 128'(key_loaded), 128'(1));
      wait_drain();

      run_blk(1, K_B, P_B, C_B);
      wait_drain();
      run_blk(0, K_B, P_F, C_F);
      wait_drain();

      p3 = 128'h0123456789abcdeffedcba9876543210;
      p4 = 128'h11111111222222223333333344444444;
      run_blk(0, K_B, p3, core_model(p3, K_B));
      rnd = 1;
      stall_n = SETTLE + 5;
      s_valid = 1; s_key = 0; s_data = p4[127:96];
      run_blk(0, K_B, p4, core_model(p4, K_B));
      wait_drain();
      rnd = 0;

      p5 = 128'hcafebabe000000005555aaaa12345678;
      run_blk(0, K_B, p5, core_model(p5, K_B));
      g = 0;
      while (!m_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("drain_reached", 128'(m_valid), 128'(1));
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      exp_q.delete();
      busy = 0;
      chk("mid_rst_m_valid", 128'(m_valid), 128'(0));
      chk("mid_rst_key_loaded", 128'(key_loaded), 128'(0));
      chk("mid_rst_s_ready", 128'(s_ready), 128'(1));
      e0 = err_cnt;
      send(0, 32'h0badf00d, 0);
      s_valid = 0;
      repeat (2) @(negedge clk);
      chk("mid_rst_err", 128'(err_cnt - e0), 128'(1));

`ifdef AES_IO_BLOCK_COUNT_EN
      chk("blk_count_rst", 128'(blk_count), 128'(0));
      run_blk(1, K_C1, P_C1, C_C1);
      run_blk(0, K_C1, P_C1, C_C1);
      run_blk(0, K_C1, P_C1, C_C1);
      wait_drain();
      chk("blk_count_3", 128'(blk_count), 128'(3));
`endif

      wait_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
